bounce_dir_ctrl: RTL and testbench

//   Direction/sequencing controller placed directly upstream of the 3-bit up/down counter.

---
 rtl/bounce_dir_ctrl.sv | 134 +++++++++++++
 tb/tb_bounce_dir_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_dir_ctrl.sv
// Direction/sequencing controller for a W-bit up/down counter: sweeps the counter
// back and forth between latched limits, counts turnarounds and flags range faults.
module bounce_dir_ctrl #(
  parameter int unsigned W  = 3,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  lo_lim,
  input  logic [W-1:0]  hi_lim,
  input  logic [W-1:0]  count_in,
  output logic          up,
  output logic          cnt_reset,
  output logic          busy,
  output logic [CW-1:0] turn_cnt,
  output logic          dir_fault,
  output logic          cfg_err
);

  localparam int unsigned WE = W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    lo_r, hi_r, lo_nxt, hi_nxt;
  logic            up_nxt, cnt_reset_nxt, busy_nxt, dir_fault_nxt, cfg_err_nxt;
  logic [CW-1:0]   turn_nxt, turn_inc;
  logic [WE-1:0]   cnt_ext, hi_m1, lo_p1;

  // Turn thresholds in W+1 bits; lo_r < hi_r guarantees no wrap while running.
  assign cnt_ext  = {1'b0, count_in};
  assign hi_m1    = {1'b0, hi_r} - WE'(1);
  assign lo_p1    = {1'b0, lo_r} + WE'(1);
  assign turn_inc = (&turn_cnt) ? turn_cnt : turn_cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      up        <= 1'b1;
      cnt_reset <= 1'b1;
      busy      <= 1'b0;
      turn_cnt  <= '0;
      dir_fault <= 1'b0;
      cfg_err   <= 1'b0;
      lo_r      <= '0;
      hi_r      <= '0;
    end else begin
      state     <= state_nxt;
      up        <= up_nxt;
      cnt_reset <= cnt_reset_nxt;
      busy      <= busy_nxt;
      turn_cnt  <= turn_nxt;
      dir_fault <= dir_fault_nxt;
      cfg_err   <= cfg_err_nxt;
      lo_r      <= lo_nxt;
      hi_r      <= hi_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    up_nxt        = up;
    cnt_reset_nxt = cnt_reset;
    busy_nxt      = busy;
    turn_nxt      = turn_cnt;
    dir_fault_nxt = dir_fault;
    cfg_err_nxt   = 1'b0;
    lo_nxt        = lo_r;
    hi_nxt        = hi_r;

    case (state)
      IDLE: begin
        cnt_reset_nxt = 1'b1;
        up_nxt        = 1'b1;
        busy_nxt      = 1'b0;
        if (start && !stop) begin
          if (lo_lim < hi_lim) begin
            lo_nxt        = lo_lim;
            hi_nxt        = hi_lim;
            turn_nxt      = '0;
            dir_fault_nxt = 1'b0;
            cnt_reset_nxt = 1'b0;
            busy_nxt      = 1'b1;
            state_nxt     = RUN_UP;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end

      RUN_UP: begin
        if (stop) begin
          state_nxt     = IDLE;
          cnt_reset_nxt = 1'b1;
          up_nxt        = 1'b1;
          busy_nxt      = 1'b0;
        end else if (cnt_ext >= hi_m1) begin
          up_nxt    = 1'b0;
          turn_nxt  = turn_inc;
          state_nxt = RUN_DOWN;
          if (count_in >= hi_r) dir_fault_nxt = 1'b1;
        end
      end

      RUN_DOWN: begin
        if (stop) begin
          state_nxt     = IDLE;
          cnt_reset_nxt = 1'b1;
          up_nxt        = 1'b1;
          busy_nxt      = 1'b0;
        end else if (cnt_ext <= lo_p1) begin
          up_nxt    = 1'b1;
          turn_nxt  = turn_inc;
          state_nxt = RUN_UP;
          if (count_in <= lo_r) dir_fault_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt     = IDLE;
        cnt_reset_nxt = 1'b1;
        up_nxt        = 1'b1;
        busy_nxt      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bounce_dir_ctrl.sv
// Closed-loop bench: controller drives a behavioural 3-bit up/down counter whose
// value is fed back; directed tables plus random sweeps against a bounce model.
module tb_bounce_dir_ctrl;
  localparam int unsigned W  = 3;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [W-1:0]  lo_lim = '0;
  logic [W-1:0]  hi_lim = '0;
  logic [W-1:0]  count_in;
  logic [W-1:0]  cnt_q = '0;
  logic [W-1:0]  glitch_val = '0;
  logic          glitch_en = 1'b0;
  logic          up, cnt_reset, busy, dir_fault, cfg_err;
  logic [CW-1:0] turn_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: position on the bounce path and direction of travel.
  bit m_run, m_desc, m_cfg;
  int m_val, m_turns, m_lo, m_hi;

  typedef struct {
    bit st, sp;
    int lo, hi;
    int e_cnt, e_up, e_crst, e_busy, e_turn, e_cfg;
  } vec_t;
  vec_t tbl[$];

  bounce_dir_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .count_in(count_in),
    .up(up), .cnt_reset(cnt_reset), .busy(busy), .turn_cnt(turn_cnt),
    .dir_fault(dir_fault), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // The downstream counter: synchronous active-high reset, wraps modulo 2^W.
  always @(posedge clk) begin
    if (cnt_reset) cnt_q <= '0;
    else if (up)   cnt_q <= cnt_q + W'(1);
    else           cnt_q <= cnt_q - W'(1);
  end

  assign count_in = glitch_en ? glitch_val : cnt_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit sp, input int lo, input int hi);
    start  = st;
    stop   = sp;
    lo_lim = W'(lo);
    hi_lim = W'(hi);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit st, bit sp, int lo, int hi, int c, int u, int cr,
                              int b, int t, int cf);
    vec_t v;
    v.st = st; v.sp = sp; v.lo = lo; v.hi = hi;
    v.e_cnt = c; v.e_up = u; v.e_crst = cr; v.e_busy = b; v.e_turn = t; v.e_cfg = cf;
    return v;
  endfunction

  task automatic model_edge(input bit st, input bit sp, input int lo, input int hi);
    m_cfg = 1'b0;
    if (m_run) begin
      m_val = (m_desc ? m_val - 1 : m_val + 1) & 7;
      if (sp) m_run = 1'b0;
      else if ((!m_desc && m_val == m_hi) || (m_desc && m_val == m_lo)) begin
        m_desc = !m_desc;
        if (m_turns < 255) m_turns++;
      end
    end else begin
      m_val = 0;
      if (st && !sp) begin
        if (lo < hi) begin
          m_run = 1'b1; m_desc = 1'b0; m_turns = 0; m_lo = lo; m_hi = hi;
        end else begin
          m_cfg = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".count"}, 32'(count_in), 32'(m_val));
    chk({nm, ".up"}, 32'(up), (m_run && m_desc) ? 32'd0 : 32'd1);
    chk({nm, ".cnt_reset"}, 32'(cnt_reset), m_run ? 32'd0 : 32'd1);
    chk({nm, ".busy"}, 32'(busy), m_run ? 32'd1 : 32'd0);
    chk({nm, ".turn_cnt"}, 32'(turn_cnt), 32'(m_turns));
    chk({nm, ".dir_fault"}, 32'(dir_fault), 32'd0);
    chk({nm, ".cfg_err"}, 32'(cfg_err), 32'(m_cfg));
  endtask

  initial begin
    // Sweep 2..5, stop, then the tight 6/7 sweep, bad configs, lo=0/hi=1 edge.
    tbl.push_back(mk(1,0,2,5, 0,1,0,1,0,0));
    tbl.push_back(mk(0,0,2,5, 1,1,0,1,0,0));
    tbl.push_back(mk(0,0,2,5, 2,1,0,1,0,0));
    tbl.push_back(mk(0,0,2,5, 3,1,0,1,0,0));
    tbl.push_back(mk(0,0,2,5, 4,1,0,1,0,0));
    tbl.push_back(mk(0,0,2,5, 5,0,0,1,1,0));
    tbl.push_back(mk(0,0,2,5, 4,0,0,1,1,0));
    tbl.push_back(mk(0,0,2,5, 3,0,0,1,1,0));
    tbl.push_back(mk(0,0,2,5, 2,1,0,1,2,0));
    tbl.push_back(mk(0,0,2,5, 3,1,0,1,2,0));
    tbl.push_back(mk(0,0,2,5, 4,1,0,1,2,0));
    tbl.push_back(mk(0,0,2,5, 5,0,0,1,3,0));
    tbl.push_back(mk(0,0,2,5, 4,0,0,1,3,0));
    tbl.push_back(mk(0,1,2,5, 3,1,1,0,3,0));
    tbl.push_back(mk(0,0,2,5, 0,1,1,0,3,0));
    tbl.push_back(mk(1,0,6,7, 0,1,0,1,0,0));
    for (int i = 1; i <= 6; i++) tbl.push_back(mk(0,0,6,7, i,1,0,1,0,0));
    tbl.push_back(mk(0,0,6,7, 7,0,0,1,1,0));
    tbl.push_back(mk(0,0,6,7, 6,1,0,1,2,0));
    tbl.push_back(mk(0,0,6,7, 7,0,0,1,3,0));
    tbl.push_back(mk(0,0,6,7, 6,1,0,1,4,0));
    tbl.push_back(mk(1,1,6,7, 7,1,1,0,4,0));
    tbl.push_back(mk(0,0,6,7, 0,1,1,0,4,0));
    tbl.push_back(mk(1,0,4,4, 0,1,1,0,4,1));
    tbl.push_back(mk(0,0,4,4, 0,1,1,0,4,0));
    tbl.push_back(mk(1,1,1,3, 0,1,1,0,4,0));
    tbl.push_back(mk(0,0,1,3, 0,1,1,0,4,0));
    tbl.push_back(mk(1,0,5,2, 0,1,1,0,4,1));
    tbl.push_back(mk(0,0,5,2, 0,1,1,0,4,0));
    tbl.push_back(mk(1,0,0,1, 0,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 1,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,1, 0,1,0,1,2,0));
    tbl.push_back(mk(0,0,0,1, 1,0,0,1,3,0));
    tbl.push_back(mk(0,1,0,1, 0,1,1,0,3,0));
    tbl.push_back(mk(0,0,0,1, 0,1,1,0,3,0));

    // Reset values appear asynchronously, before any clock edge.
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst.up", 32'(up), 32'd1);
    chk("rst.cnt_reset", 32'(cnt_reset), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.turn_cnt", 32'(turn_cnt), 32'd0);
    chk("rst.dir_fault", 32'(dir_fault), 32'd0);
    chk("rst.cfg_err", 32'(cfg_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (3) tick();
    chk("idle.count", 32'(count_in), 32'd0);
    chk("idle.cnt_reset", 32'(cnt_reset), 32'd1);
    chk("idle.busy", 32'(busy), 32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].lo, tbl[i].hi);
      tick();
      chk($sformatf("tbl%0d.count", i), 32'(count_in), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.up", i), 32'(up), 32'(tbl[i].e_up));
      chk($sformatf("tbl%0d.cnt_reset", i), 32'(cnt_reset), 32'(tbl[i].e_crst));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.turn_cnt", i), 32'(turn_cnt), 32'(tbl[i].e_turn));
      chk($sformatf("tbl%0d.cfg_err", i), 32'(cfg_err), 32'(tbl[i].e_cfg));
      chk($sformatf("tbl%0d.dir_fault", i), 32'(dir_fault), 32'd0);
    end
    drive(0, 0, 0, 0);

    // Turnaround counter saturation with a turn on every edge.
    drive(1, 0, 6, 7);
    tick();
    drive(0, 0, 6, 7);
    repeat (300) tick();
    chk("sat.turn_cnt", 32'(turn_cnt), 32'd255);
    chk("sat.busy", 32'(busy), 32'd1);
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();

    // Glitch: during descent the counter appears to jump to lo_r.
    drive(1, 0, 2, 6);
    tick();
    drive(0, 0, 2, 6);
    repeat (7) tick();
    chk("glitch.pre_count", 32'(count_in), 32'd5);
    chk("glitch.pre_up", 32'(up), 32'd0);
    glitch_val = 3'd2;
    glitch_en  = 1'b1;
    tick();
    glitch_en  = 1'b0;
    chk("glitch.dir_fault", 32'(dir_fault), 32'd1);
    chk("glitch.up", 32'(up), 32'd1);
    chk("glitch.turn_cnt", 32'(turn_cnt), 32'd2);
    repeat (3) tick();
    chk("glitch.sticky", 32'(dir_fault), 32'd1);
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("glitch.stop_keeps", 32'(dir_fault), 32'd1);
    drive(1, 0, 2, 6);
    tick();
    drive(0, 0, 0, 0);
    chk("glitch.cleared", 32'(dir_fault), 32'd0);

    // Reset in the middle of a sweep, between clock edges.
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("midrst.up", 32'(up), 32'd1);
    chk("midrst.cnt_reset", 32'(cnt_reset), 32'd1);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.turn_cnt", 32'(turn_cnt), 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("midrst.count", 32'(count_in), 32'd0);

    // Random sweeps against the bounce model.
    m_run = 1'b0; m_desc = 1'b0; m_cfg = 1'b0;
    m_val = 0; m_turns = 0; m_lo = 0; m_hi = 0;
    for (int i = 0; i < 4000; i++) begin
      bit st, sp;
      int lo, hi;
      lo = int'($urandom_range(0, 7));
      hi = int'($urandom_range(0, 7));
      if (m_run) begin
        st = ($urandom_range(0, 9) == 0);
        sp = ($urandom_range(0, 29) == 0);
      end else begin
        st = ($urandom_range(0, 2) == 0);
        sp = ($urandom_range(0, 7) == 0);
      end
      drive(st, sp, lo, hi);
      model_edge(st, sp, lo, hi);
      tick();
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
